pr_bus_arbiter: RTL and testbench

- Shares the CPU-side Bridge port (PrAddr/PrWD/Prbyteen/PrRD) between two masters: M0 (CPU data port, preferred) and M1 (secondary requester, e.g. a DMA/debug port).
- Every access is a fixed two-phase transaction: arbitration in IDLE, then one ACCESS cycle on the Pr bus.
- Fixed priority to M0, with a starvation guard that forces M1 through after MAX_WAIT lost arbitrations.

---
 rtl/pr_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_pr_bus_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_bus_arbiter.sv
// ============================================================================
// pr_bus_arbiter
//
// Purpose:
//   Shares the CPU-side Bridge port (PrAddr/PrWD/Prbyteen/PrRD) between two
//   masters. M0 (CPU data port) has fixed priority. M1 (DMA/debug port) is
//   forced through after MAX_WAIT consecutive M0 wins while M1 is waiting.
//   Every access has two phases: arbitration in IDLE, then one ACCESS cycle
//   on the Pr bus. The best case is one access every two cycles.
//
// Parameters:
//   MAX_WAIT   M0 wins in a row, with M1 requesting, before M1 must win (1..15)
//
// Ports:
//   clk                   system clock, rising edge
//   reset                 asynchronous, active-low reset
//   m0_req / m1_req       request; held with its command until gnt
//   m0_addr / m1_addr     byte address
//   m0_wd / m1_wd         write data
//   m0_byteen / m1_byteen byte enables, 4'b0000 = read
//   m0_gnt / m1_gnt       command accepted this cycle (combinational)
//   m0_rd / m1_rd         registered read data
//   m0_rvalid / m1_rvalid one-cycle completion pulse (reads and writes)
//   PrAddr/PrWD/Prbyteen  Bridge command, zero outside ACCESS
//   PrRD                  Bridge read data, valid during ACCESS
//   busy                  high during ACCESS
//   owner                 master of the current or last access (0 = M0)
// ============================================================================
module pr_bus_arbiter #(
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic [31:0] m0_rd,
    output logic        m0_rvalid,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic [31:0] m1_rd,
    output logic        m1_rvalid,

    output logic [31:0] PrAddr,
    output logic [31:0] PrWD,
    output logic [3:0]  Prbyteen,
    input  logic [31:0] PrRD,
    output logic        busy,
    output logic        owner
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [3:0]  r_byteen;
    logic        r_owner;
    logic [3:0]  r_waitCnt;
    logic [31:0] r_m0Rd;
    logic [31:0] r_m1Rd;
    logic        r_m0Rvalid;
    logic        r_m1Rvalid;

    logic        w_m0Win;
    logic        w_m1Win;

    // Arbitration is evaluated only in IDLE. M1 wins when M0 is quiet, or
    // when M0 has already won MAX_WAIT times in a row while M1 was waiting.
    assign w_m1Win = (r_state == IDLE) && m1_req &&
                     (!m0_req || (r_waitCnt == WAIT_LIMIT));
    assign w_m0Win = (r_state == IDLE) && m0_req && !w_m1Win;

    assign m0_gnt    = w_m0Win;
    assign m1_gnt    = w_m1Win;
    assign m0_rd     = r_m0Rd;
    assign m1_rd     = r_m1Rd;
    assign m0_rvalid = r_m0Rvalid;
    assign m1_rvalid = r_m1Rvalid;
    assign owner     = r_owner;

    // State register. The asynchronous reset forces IDLE, so the Pr outputs,
    // which are decoded from the state, drop to zero at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and Pr bus decode. The Bridge sees a command only during
    // ACCESS, so it can never observe a stray write in any other cycle.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        PrAddr      = 32'h0;
        PrWD        = 32'h0;
        Prbyteen    = 4'h0;
        case (r_state)
            IDLE: begin
                if (w_m0Win || w_m1Win) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                busy        = 1'b1;
                PrAddr      = r_addr;
                PrWD        = r_wd;
                Prbyteen    = r_byteen;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Command latch, starvation counter and completion registers. rvalid is
    // a single-cycle pulse. It is cleared every cycle unless an ACCESS
    // closes on this edge. A write still pulses rvalid as its acknowledge,
    // but it leaves the read register unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= 32'h0;
            r_wd       <= 32'h0;
            r_byteen   <= 4'h0;
            r_owner    <= 1'b0;
            r_waitCnt  <= 4'h0;
            r_m0Rd     <= 32'h0;
            r_m1Rd     <= 32'h0;
            r_m0Rvalid <= 1'b0;
            r_m1Rvalid <= 1'b0;
        end else begin
            r_m0Rvalid <= 1'b0;
            r_m1Rvalid <= 1'b0;

            if (w_m1Win) begin
                r_addr    <= m1_addr;
                r_wd      <= m1_wd;
                r_byteen  <= m1_byteen;
                r_owner   <= 1'b1;
                r_waitCnt <= 4'h0;
            end else if (w_m0Win) begin
                r_addr   <= m0_addr;
                r_wd     <= m0_wd;
                r_byteen <= m0_byteen;
                r_owner  <= 1'b0;
                if (m1_req && (r_waitCnt != WAIT_LIMIT)) begin
                    r_waitCnt <= r_waitCnt + 4'h1;
                end
            end

            if (r_state == ACCESS) begin
                if (r_owner) begin
                    r_m1Rvalid <= 1'b1;
                    if (r_byteen == 4'h0) begin
                        r_m1Rd <= PrRD;
                    end
                end else begin
                    r_m0Rvalid <= 1'b1;
                    if (r_byteen == 4'h0) begin
                        r_m0Rd <= PrRD;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// ============================================================================
// tb_pr_bus_arbiter
//
// Directed bench for pr_bus_arbiter with MAX_WAIT = 3. Inputs change 1 ns
// after a rising edge. Outputs are sampled on the falling edge. Each
// scenario task drives its own vectors and compares against hand-computed
// values.
// ============================================================================
module tb_pr_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic [3:0]  m0_byteen;
    logic        m0_gnt;
    logic [31:0] m0_rd;
    logic        m0_rvalid;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic [3:0]  m1_byteen;
    logic        m1_gnt;
    logic [31:0] m1_rd;
    logic        m1_rvalid;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic [3:0]  Prbyteen;
    logic [31:0] PrRD;
    logic        busy;
    logic        owner;

    int testsRun;
    int testsFailed;

    pr_bus_arbiter #(
        .MAX_WAIT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wd     (m0_wd),
        .m0_byteen (m0_byteen),
        .m0_gnt    (m0_gnt),
        .m0_rd     (m0_rd),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wd     (m1_wd),
        .m1_byteen (m1_byteen),
        .m1_gnt    (m1_gnt),
        .m1_rd     (m1_rd),
        .m1_rvalid (m1_rvalid),
        .PrAddr    (PrAddr),
        .PrWD      (PrWD),
        .Prbyteen  (Prbyteen),
        .PrRD      (PrRD),
        .busy      (busy),
        .owner     (owner)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time %0t reached, limit 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset held low: everything visible must be zero
    task automatic test_reset();
        @(negedge clk);
        testsRun++;
        if ({PrAddr, PrWD, Prbyteen} !== 68'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_pr: got %h/%h/%h expected 0/0/0", PrAddr, PrWD, Prbyteen);
        end
        testsRun++;
        if ({busy, owner, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt} !== 6'b000000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {busy, owner, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt});
        end
        testsRun++;
        if ({m0_rd, m1_rd} !== 64'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_rd: got %h/%h expected 0/0", m0_rd, m1_rd);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Single M0 read of 0x10 returning 6
    task automatic test_m0_read();
        @(posedge clk); #1;
        m0_req = 1'b1; m0_addr = 32'h0000_0010; m0_wd = 32'h0; m0_byteen = 4'h0;
        PrRD = 32'h0000_0006;
        @(negedge clk);
        testsRun++;
        if ({m0_gnt, m1_gnt, busy} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL m0rd_gnt: got gnt0/gnt1/busy=%b expected 100", {m0_gnt, m1_gnt, busy});
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({busy, PrAddr, Prbyteen, m0_gnt, owner} !== {1'b1, 32'h10, 4'h0, 1'b0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL m0rd_access: got busy=%b addr=%h be=%h gnt=%b owner=%b expected 1 00000010 0 0 0",
                     busy, PrAddr, Prbyteen, m0_gnt, owner);
        end
        @(posedge clk); #1;
        @(negedge clk);
        testsRun++;
        if ({m0_rvalid, m0_rd} !== {1'b1, 32'h6}) begin
            testsFailed++;
            $display("[TB] FAIL m0rd_data: got rvalid=%b rd=%h expected 1 00000006", m0_rvalid, m0_rd);
        end
        testsRun++;
        if ({m1_rvalid, m1_rd, busy} !== {1'b0, 32'h0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL m0rd_m1quiet: got m1_rvalid=%b m1_rd=%h busy=%b expected 0 0 0",
                     m1_rvalid, m1_rd, busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        testsRun++;
        if ({m0_rvalid, m0_rd} !== {1'b0, 32'h6}) begin
            testsFailed++;
            $display("[TB] FAIL m0rd_pulse: got rvalid=%b rd=%h expected 0 00000006", m0_rvalid, m0_rd);
        end
    endtask

    // Single M1 write of 7 to 0x7F00
    task automatic test_m1_write();
        @(posedge clk); #1;
        m0_req = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h0000_7F00; m1_wd = 32'h7; m1_byteen = 4'hF;
        PrRD = 32'hDEAD_BEEF;
        @(negedge clk);
        testsRun++;
        if ({m1_gnt, m0_gnt} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL m1wr_gnt: got gnt1/gnt0=%b expected 10", {m1_gnt, m0_gnt});
        end
        @(posedge clk); #1;
        m1_req = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({busy, owner, PrAddr, PrWD, Prbyteen} !== {1'b1, 1'b1, 32'h7F00, 32'h7, 4'hF}) begin
            testsFailed++;
            $display("[TB] FAIL m1wr_access: got busy=%b owner=%b addr=%h wd=%h be=%h expected 1 1 00007f00 00000007 f",
                     busy, owner, PrAddr, PrWD, Prbyteen);
        end
        @(posedge clk); #1;
        @(negedge clk);
        testsRun++;
        if ({busy, PrAddr, PrWD, Prbyteen} !== 69'h0) begin
            testsFailed++;
            $display("[TB] FAIL m1wr_release: got busy=%b addr=%h wd=%h be=%h expected all 0",
                     busy, PrAddr, PrWD, Prbyteen);
        end
        testsRun++;
        if ({m1_rvalid, m1_rd, m0_rvalid, m0_rd} !== {1'b1, 32'h0, 1'b0, 32'h6}) begin
            testsFailed++;
            $display("[TB] FAIL m1wr_ack: got m1_rvalid=%b m1_rd=%h m0_rvalid=%b m0_rd=%h expected 1 0 0 6",
                     m1_rvalid, m1_rd, m0_rvalid, m0_rd);
        end
    endtask

    // Both requests held: M0,M0,M0,M1 repeating, one access per two cycles
    task automatic test_contention();
        logic [7:0] expM1;
        int g;
        expM1 = 8'b1000_1000;
        g = 0;
        @(posedge clk); #1;
        m0_req = 1'b1; m0_addr = 32'h0000_0020; m0_wd = 32'h0; m0_byteen = 4'h0;
        m1_req = 1'b1; m1_addr = 32'h0000_0030; m1_wd = 32'h0; m1_byteen = 4'h0;
        PrRD = 32'h0000_00AA;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (cyc % 2 == 0) begin
                g = cyc / 2;
                testsRun++;
                if ({m1_gnt, m0_gnt, busy} !== (expM1[g] ? 3'b100 : 3'b010)) begin
                    testsFailed++;
                    $display("[TB] FAIL contention_grant%0d: got gnt1/gnt0/busy=%b expected %b",
                             g, {m1_gnt, m0_gnt, busy}, (expM1[g] ? 3'b100 : 3'b010));
                end
                if (g > 0) begin
                    testsRun++;
                    if ({m1_rvalid, m0_rvalid} !== (expM1[g-1] ? 2'b10 : 2'b01)) begin
                        testsFailed++;
                        $display("[TB] FAIL contention_rvalid%0d: got rv1/rv0=%b expected %b",
                                 g - 1, {m1_rvalid, m0_rvalid}, (expM1[g-1] ? 2'b10 : 2'b01));
                    end
                end
            end else begin
                testsRun++;
                if ({busy, owner, m1_gnt, m0_gnt} !== {1'b1, expM1[g], 2'b00}) begin
                    testsFailed++;
                    $display("[TB] FAIL contention_access%0d: got busy/owner/gnt1/gnt0=%b expected %b",
                             g, {busy, owner, m1_gnt, m0_gnt}, {1'b1, expM1[g], 2'b00});
                end
            end
            @(posedge clk); #1;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({m1_rvalid, m0_rvalid, m1_gnt, m0_gnt} !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL contention_tail: got rv1/rv0/gnt1/gnt0=%b expected 1000",
                     {m1_rvalid, m0_rvalid, m1_gnt, m0_gnt});
        end
    endtask

    // Back-to-back M0 reads: the second gnt lands in the first rvalid cycle
    task automatic test_back_to_back();
        @(posedge clk); #1;
        m0_req = 1'b1; m0_addr = 32'h0000_0000; m0_byteen = 4'h0;
        PrRD = 32'h1111_0000;
        @(negedge clk);
        testsRun++;
        if (m0_gnt !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_gnt1: got %b expected 1", m0_gnt);
        end
        @(posedge clk); #1;
        m0_addr = 32'h0000_0004;
        @(negedge clk);
        testsRun++;
        if ({busy, m0_gnt, PrAddr, Prbyteen} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_access1: got busy=%b gnt=%b addr=%h be=%h expected 1 0 0 0",
                     busy, m0_gnt, PrAddr, Prbyteen);
        end
        @(posedge clk); #1;
        PrRD = 32'h2222_0004;
        @(negedge clk);
        testsRun++;
        if ({m0_rvalid, m0_gnt, busy, Prbyteen, m0_rd} !== {1'b1, 1'b1, 1'b0, 4'h0, 32'h1111_0000}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_overlap: got rvalid=%b gnt=%b busy=%b be=%h rd=%h expected 1 1 0 0 11110000",
                     m0_rvalid, m0_gnt, busy, Prbyteen, m0_rd);
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({busy, PrAddr, m0_rvalid} !== {1'b1, 32'h4, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_access2: got busy=%b addr=%h rvalid=%b expected 1 00000004 0",
                     busy, PrAddr, m0_rvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        testsRun++;
        if ({m0_rvalid, m0_rd, m0_gnt} !== {1'b1, 32'h2222_0004, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_data2: got rvalid=%b rd=%h gnt=%b expected 1 22220004 0",
                     m0_rvalid, m0_rd, m0_gnt);
        end
    endtask

    // Reset in the middle of an M0 write; the starvation count must restart
    task automatic test_reset_mid_access();
        logic [3:0] expM1;
        int g;
        expM1 = 4'b1000;
        g = 0;
        @(posedge clk); #1;
        m0_req = 1'b1; m0_addr = 32'h0000_0100; m0_wd = 32'h0000_CAFE; m0_byteen = 4'hF;
        m1_req = 1'b1; m1_addr = 32'h0000_0200; m1_wd = 32'h0; m1_byteen = 4'h0;
        @(negedge clk);
        testsRun++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_gnt: got gnt0/gnt1=%b expected 10", {m0_gnt, m1_gnt});
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({busy, Prbyteen, PrWD} !== {1'b1, 4'hF, 32'h0000_CAFE}) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_access: got busy=%b be=%h wd=%h expected 1 f 0000cafe",
                     busy, Prbyteen, PrWD);
        end
        #2;
        reset = 1'b0;
        #1;
        testsRun++;
        if ({busy, Prbyteen, PrWD, PrAddr, m0_rd} !== 101'h0) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_async: got busy=%b be=%h wd=%h addr=%h rd=%h expected all 0",
                     busy, Prbyteen, PrWD, PrAddr, m0_rd);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            testsRun++;
            if ({m0_rvalid, m1_rvalid, busy} !== 3'b000) begin
                testsFailed++;
                $display("[TB] FAIL rstmid_norvalid%0d: got rv0/rv1/busy=%b expected 000",
                         k, {m0_rvalid, m1_rvalid, busy});
            end
            @(posedge clk); #1;
        end
        m0_req = 1'b1; m0_byteen = 4'h0;
        m1_req = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (cyc % 2 == 0) begin
                g = cyc / 2;
                testsRun++;
                if ({m1_gnt, m0_gnt} !== (expM1[g] ? 2'b10 : 2'b01)) begin
                    testsFailed++;
                    $display("[TB] FAIL rstmid_grant%0d: got gnt1/gnt0=%b expected %b",
                             g, {m1_gnt, m0_gnt}, (expM1[g] ? 2'b10 : 2'b01));
                end
            end
            @(posedge clk); #1;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    // Idle bus: ten quiet cycles with every output at rest
    task automatic test_idle_bus();
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            testsRun++;
            if ({PrAddr, PrWD, Prbyteen, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy} !== 73'h0) begin
                testsFailed++;
                $display("[TB] FAIL idle%0d: got addr=%h wd=%h be=%h gnt0/gnt1/rv0/rv1/busy=%b expected all 0",
                         k, PrAddr, PrWD, Prbyteen, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy});
            end
            @(posedge clk); #1;
        end
    endtask

    // Run the scenarios in order, then report
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b0;
        m0_req      = 1'b0;
        m0_addr     = 32'h0;
        m0_wd       = 32'h0;
        m0_byteen   = 4'h0;
        m1_req      = 1'b0;
        m1_addr     = 32'h0;
        m1_wd       = 32'h0;
        m1_byteen   = 4'h0;
        PrRD        = 32'h0;

        test_reset();
        test_m0_read();
        test_m1_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_access();
        test_idle_bus();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
